// File: rtl/gactx_pkg.sv
// rtl/gactx_pkg.sv - shared op codes, direction codes and FSM state type for the CIGAR emitter
package gactx_pkg;

  localparam logic [1:0] OP_M        = 2'd0;
  localparam logic [1:0] OP_I        = 2'd1;
  localparam logic [1:0] OP_D        = 2'd2;
  localparam logic [1:0] DIR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_UNPACK = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/gactx_dir_cigar_if.sv
// rtl/gactx_dir_cigar_if.sv - run-length op stream with valid/ready handshake
interface gactx_dir_cigar_if #(
  parameter int OP_LEN_WIDTH = 16
);
  logic                    op_valid;
  logic                    op_ready;
  logic [1:0]              op_code;
  logic [OP_LEN_WIDTH-1:0] op_len;
  logic                    op_last;

  modport master (output op_valid, op_code, op_len, op_last, input op_ready);
  modport slave  (input op_valid, op_code, op_len, op_last, output op_ready);
endinterface

// File: rtl/gactx_run_merger.sv
// rtl/gactx_run_merger.sv - run accumulator feeding a single-entry output slot
module gactx_run_merger
  import gactx_pkg::*;
#(
  parameter int OP_LEN_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       dir_valid,
  input  logic [1:0] dir,
  input  logic       flush,
  output logic       stall,
  output logic       run_empty,
  gactx_dir_cigar_if.master op_if
);

  localparam logic [OP_LEN_WIDTH-1:0] LEN_MAX = '1;
  localparam logic [OP_LEN_WIDTH-1:0] LEN_ONE = OP_LEN_WIDTH'(1);

  logic [1:0]              run_op_q, run_op_d;
  logic [OP_LEN_WIDTH-1:0] run_len_q, run_len_d;
  logic                    op_valid_q, op_valid_d;
  logic [1:0]              op_code_q, op_code_d;
  logic [OP_LEN_WIDTH-1:0] op_len_q, op_len_d;
  logic                    op_last_q, op_last_d;
  logic                    accept;

  always_comb begin
    accept     = op_valid_q && op_if.op_ready;
    stall      = op_valid_q && !op_if.op_ready;
    run_empty  = (run_len_q == '0);
    run_op_d   = run_op_q;
    run_len_d  = run_len_q;
    op_valid_d = op_valid_q && !accept;
    op_code_d  = op_code_q;
    op_len_d   = op_len_q;
    op_last_d  = op_last_q;

    if (clear) begin
      run_op_d  = '0;
      run_len_d = '0;
    end else if (!stall) begin
      if (dir_valid && dir != DIR_INVALID) begin
        if (run_empty) begin
          run_op_d  = dir;
          run_len_d = LEN_ONE;
        end else if (dir == run_op_q && run_len_q != LEN_MAX) begin
          run_len_d = run_len_q + LEN_ONE;
        end else begin
          op_valid_d = 1'b1;
          op_code_d  = run_op_q;
          op_len_d   = run_len_q;
          op_last_d  = 1'b0;
          run_op_d   = dir;
          run_len_d  = LEN_ONE;
        end
      end else if (flush && !run_empty) begin
        op_valid_d = 1'b1;
        op_code_d  = run_op_q;
        op_len_d   = run_len_q;
        op_last_d  = 1'b1;
        run_op_d   = '0;
        run_len_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_op_q   <= '0;
      run_len_q  <= '0;
      op_valid_q <= 1'b0;
      op_code_q  <= '0;
      op_len_q   <= '0;
      op_last_q  <= 1'b0;
    end else begin
      run_op_q   <= run_op_d;
      run_len_q  <= run_len_d;
      op_valid_q <= op_valid_d;
      op_code_q  <= op_code_d;
      op_len_q   <= op_len_d;
      op_last_q  <= op_last_d;
    end
  end

  assign op_if.op_valid = op_valid_q;
  assign op_if.op_code  = op_code_q;
  assign op_if.op_len   = op_len_q;
  assign op_if.op_last  = op_last_q;

endmodule

// File: rtl/gactx_dir_cigar.sv
// rtl/gactx_dir_cigar.sv - reads packed traceback directions from BRAM and emits merged ops
module gactx_dir_cigar
  import gactx_pkg::*;
#(
  parameter int NUM_DIR_BLOCK       = 32,
  parameter int DIR_BRAM_ADDR_WIDTH = 14,
  parameter int LOG_MAX_TILE_SIZE   = 13,
  parameter int OP_LEN_WIDTH        = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [2*LOG_MAX_TILE_SIZE-1:0]   num_tb_steps,
  output logic [DIR_BRAM_ADDR_WIDTH-1:0]   dir_rd_addr,
  input  logic [2*NUM_DIR_BLOCK-1:0]       dir_data_in,
  gactx_dir_cigar_if.master                op_if,
  output logic                             busy,
  output logic                             done,
  input  logic                             clear_done,
  output logic                             dir_err
);

  localparam int STEPS_W = 2 * LOG_MAX_TILE_SIZE;
  localparam int IDX_W   = $clog2(NUM_DIR_BLOCK);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_DIR_BLOCK - 1);
  localparam logic [STEPS_W-1:0] STEPS_ONE = STEPS_W'(1);

  state_e                           state_q, state_d;
  logic [DIR_BRAM_ADDR_WIDTH-1:0]   word_addr_q, word_addr_d;
  logic [DIR_BRAM_ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [2*NUM_DIR_BLOCK-1:0]       shift_q, shift_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [STEPS_W-1:0]               steps_left_q, steps_left_d;
  logic                             dir_err_q, dir_err_d;

  logic merge_clear, merge_dir_valid, merge_flush, merge_stall, merge_run_empty;

  always_comb begin
    state_d         = state_q;
    word_addr_d     = word_addr_q;
    rd_addr_d       = rd_addr_q;
    shift_d         = shift_q;
    idx_d           = idx_q;
    steps_left_d    = steps_left_q;
    dir_err_d       = dir_err_q;
    merge_clear     = 1'b0;
    merge_dir_valid = 1'b0;
    merge_flush     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          steps_left_d = num_tb_steps;
          word_addr_d  = '0;
          rd_addr_d    = '0;
          dir_err_d    = 1'b0;
          merge_clear  = 1'b1;
          state_d      = (num_tb_steps == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        shift_d     = dir_data_in;
        idx_d       = '0;
        word_addr_d = word_addr_q + 1'b1;
        state_d     = ST_UNPACK;
      end
      ST_UNPACK: begin
        merge_dir_valid = 1'b1;
        // Merger stall freezes all bookkeeping so no direction is lost.
        if (!merge_stall) begin
          shift_d      = shift_q >> 2;
          idx_d        = idx_q + 1'b1;
          steps_left_d = steps_left_q - STEPS_ONE;
          if (shift_q[1:0] == DIR_INVALID) dir_err_d = 1'b1;
          if (steps_left_q == STEPS_ONE) begin
            state_d = ST_FLUSH;
          end else if (idx_q == IDX_LAST) begin
            rd_addr_d = word_addr_q;
            state_d   = ST_FETCH;
          end
        end
      end
      ST_FLUSH: begin
        merge_flush = 1'b1;
        if (merge_run_empty && !merge_stall) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (clear_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      word_addr_q  <= '0;
      rd_addr_q    <= '0;
      shift_q      <= '0;
      idx_q        <= '0;
      steps_left_q <= '0;
      dir_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_addr_q  <= word_addr_d;
      rd_addr_q    <= rd_addr_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      steps_left_q <= steps_left_d;
      dir_err_q    <= dir_err_d;
    end
  end

  assign dir_rd_addr = rd_addr_q;
  assign dir_err     = dir_err_q;
  assign done        = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);

  gactx_run_merger #(
    .OP_LEN_WIDTH(OP_LEN_WIDTH)
  ) u_merger (
    .clk       (clk),
    .rst_n     (rst),
    .clear     (merge_clear),
    .dir_valid (merge_dir_valid),
    .dir       (shift_q[1:0]),
    .flush     (merge_flush),
    .stall     (merge_stall),
    .run_empty (merge_run_empty),
    .op_if     (op_if)
  );

endmodule

// File: tb/tb_gactx_dir_cigar.sv
// tb/tb_gactx_dir_cigar.sv - scoreboard bench: random direction streams vs run-length reference model
module tb_gactx_dir_cigar;

  typedef struct {
    logic [1:0] code;
    int         len;
    logic       last;
  } op_t;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        start_a, start_b, clear_a, clear_b;
  logic [25:0] steps_a, steps_b;
  logic [13:0] addr_a, addr_b;
  logic [63:0] data_a, data_b;
  logic        busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [63:0] mem_a [16];
  logic [63:0] mem_b [16];

  gactx_dir_cigar_if #(.OP_LEN_WIDTH(16)) if_a ();
  gactx_dir_cigar_if #(.OP_LEN_WIDTH(4))  if_b ();

  gactx_dir_cigar #(.OP_LEN_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .num_tb_steps(steps_a),
    .dir_rd_addr(addr_a), .dir_data_in(data_a), .op_if(if_a),
    .busy(busy_a), .done(done_a), .clear_done(clear_a), .dir_err(err_a)
  );

  gactx_dir_cigar #(.OP_LEN_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .num_tb_steps(steps_b),
    .dir_rd_addr(addr_b), .dir_data_in(data_b), .op_if(if_b),
    .busy(busy_b), .done(done_b), .clear_done(clear_b), .dir_err(err_b)
  );

  always @(posedge clk) begin
    data_a <= mem_a[addr_a[3:0]];
    data_b <= mem_b[addr_b[3:0]];
  end

  int   n_checks = 0;
  int   n_pass   = 0;
  op_t  exp_a[$];
  op_t  exp_b[$];
  int   dirs[$];
  int   rmode_a = 0, rmode_b = 0;
  logic [31:0] seen_a, seen_b;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pop(input int sel, input logic [1:0] code, input int len, input logic last);
    op_t e;
    if ((sel == 0 && exp_a.size() == 0) || (sel == 1 && exp_b.size() == 0)) begin
      n_checks++;
      $display("FAIL unexpected_op dut%0d: got code=%0d len=%0d last=%0d expected none", sel, code, len, last);
      return;
    end
    e = (sel == 0) ? exp_a.pop_front() : exp_b.pop_front();
    chk($sformatf("op_dut%0d", sel), {code, len, last}, {e.code, e.len, e.last});
  endtask

  // Reference: drop invalid codes, split into maximal equal runs, chop each run at maxlen.
  task automatic build_expect(input int sel, input int maxlen);
    int   v[$];
    op_t  ops[$];
    int   i, j, run, c;
    foreach (dirs[k]) if (dirs[k] != 3) v.push_back(dirs[k]);
    i = 0;
    while (i < v.size()) begin
      j = i;
      while (j < v.size() && v[j] == v[i]) j++;
      run = j - i;
      while (run > 0) begin
        c = (run > maxlen) ? maxlen : run;
        ops.push_back('{code: 2'(v[i]), len: c, last: 1'b0});
        run -= c;
      end
      i = j;
    end
    if (ops.size() > 0) ops[ops.size()-1].last = 1'b1;
    foreach (ops[k]) begin
      if (sel == 0) exp_a.push_back(ops[k]);
      else exp_b.push_back(ops[k]);
    end
  endtask

  task automatic load_mem(input int sel);
    logic [63:0] w;
    for (int k = 0; k < 16; k++) begin
      w = {$urandom, $urandom};
      for (int b = 0; b < 32; b++)
        if (k * 32 + b < dirs.size()) w[2*b +: 2] = 2'(dirs[k*32+b]);
      if (sel == 0) mem_a[k] = w;
      else mem_b[k] = w;
    end
  endtask

  task automatic run_job(input int sel, input int ready_mode, input bit poke);
    int n, nerr, t, nwords;
    logic [31:0] mask;
    n = dirs.size();
    nerr = 0;
    foreach (dirs[k]) if (dirs[k] == 3) nerr++;
    load_mem(sel);
    build_expect(sel, (sel == 0) ? 65535 : 15);
    nwords = (n + 31) / 32;
    mask = (nwords == 0) ? 32'd0 : ((32'd1 << nwords) - 32'd1);
    if (sel == 0) begin
      seen_a = '0; rmode_a = ready_mode; steps_a = 26'(n); start_a = 1'b1;
    end else begin
      seen_b = '0; rmode_b = ready_mode; steps_b = 26'(n); start_b = 1'b1;
    end
    step();
    start_a = 1'b0;
    start_b = 1'b0;
    if (n == 0) chk("zero_steps_done", (sel == 0) ? done_a : done_b, 1);
    if (poke) begin
      repeat (3) step();
      start_a = 1'b1;
      steps_a = 26'd5;
      step();
      start_a = 1'b0;
    end
    t = 0;
    while (!((sel == 0) ? done_a : done_b) && t < 5000) begin
      step();
      t++;
    end
    chk("done_within_budget", t < 5000, 1);
    chk("queue_drained", (sel == 0) ? exp_a.size() : exp_b.size(), 0);
    chk("dir_err", (sel == 0) ? err_a : err_b, nerr > 0);
    chk("busy_in_done", (sel == 0) ? busy_a : busy_b, 0);
    chk("words_read", (sel == 0) ? seen_a : seen_b, mask);
    if (n == 0) chk("zero_steps_addr", (sel == 0) ? addr_a : addr_b, 0);
    if (sel == 0) clear_a = 1'b1;
    else clear_b = 1'b1;
    step();
    clear_a = 1'b0;
    clear_b = 1'b0;
    chk("done_cleared", (sel == 0) ? done_a : done_b, 0);
    exp_a.delete();
    exp_b.delete();
  endtask

  initial begin
    if_a.op_ready = 1'b1;
    if_b.op_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode_a)
        0: if_a.op_ready = 1'b1;
        1: if_a.op_ready = ~if_a.op_ready;
        2: if_a.op_ready = 1'($urandom_range(0, 1));
        default: if_a.op_ready = 1'b0;
      endcase
      case (rmode_b)
        0: if_b.op_ready = 1'b1;
        1: if_b.op_ready = ~if_b.op_ready;
        2: if_b.op_ready = 1'($urandom_range(0, 1));
        default: if_b.op_ready = 1'b0;
      endcase
    end
  end

  logic        stl_a = 1'b0, stl_b = 1'b0;
  logic [19:0] snap_a;
  logic [7:0]  snap_b;

  always @(negedge clk) begin
    if (!rst) begin
      stl_a = 1'b0;
      stl_b = 1'b0;
    end else begin
      if (busy_a) seen_a |= (addr_a < 14'd16) ? (32'd1 << addr_a) : 32'h8000_0000;
      if (busy_b) seen_b |= (addr_b < 14'd16) ? (32'd1 << addr_b) : 32'h8000_0000;
      if (stl_a) chk("stable_a", {if_a.op_valid, if_a.op_code, if_a.op_len, if_a.op_last}, snap_a);
      if (stl_b) chk("stable_b", {if_b.op_valid, if_b.op_code, if_b.op_len, if_b.op_last}, snap_b);
      if (if_a.op_valid && if_a.op_ready) check_pop(0, if_a.op_code, int'(if_a.op_len), if_a.op_last);
      if (if_b.op_valid && if_b.op_ready) check_pop(1, if_b.op_code, int'(if_b.op_len), if_b.op_last);
      stl_a  = if_a.op_valid && !if_a.op_ready;
      stl_b  = if_b.op_valid && !if_b.op_ready;
      snap_a = {if_a.op_valid, if_a.op_code, if_a.op_len, if_a.op_last};
      snap_b = {if_b.op_valid, if_b.op_code, if_b.op_len, if_b.op_last};
    end
  end

  initial begin
    int t, n;
    rst = 1'b0;
    start_a = 1'b0; start_b = 1'b0; clear_a = 1'b0; clear_b = 1'b0;
    steps_a = '0; steps_b = '0;
    seen_a = '0; seen_b = '0;
    for (int k = 0; k < 16; k++) begin mem_a[k] = '0; mem_b[k] = '0; end
    repeat (3) step();
    chk("rst_addr", addr_a, 0);
    chk("rst_valid", if_a.op_valid, 0);
    chk("rst_code", if_a.op_code, 0);
    chk("rst_len", if_a.op_len, 0);
    chk("rst_last", if_a.op_last, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_b_valid", if_b.op_valid, 0);
    rst = 1'b1;
    step();

    dirs = '{0, 0, 1, 1, 2};
    run_job(0, 0, 0);
    dirs.delete();
    repeat (70) dirs.push_back(0);
    run_job(0, 2, 0);
    dirs.delete();
    run_job(0, 0, 0);
    dirs.delete();
    for (int k = 0; k < 40; k++) dirs.push_back((k % 2 == 0) ? 0 : 2);
    run_job(0, 1, 0);
    dirs = '{3, 3, 3};
    run_job(0, 0, 0);
    for (int r = 0; r < 6; r++) begin
      dirs.delete();
      n = $urandom_range(1, 200);
      for (int k = 0; k < n; k++)
        dirs.push_back(($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2));
      run_job(0, r % 3, r == 2);
    end

    dirs.delete();
    repeat (20) dirs.push_back(1);
    run_job(1, 0, 0);
    dirs.delete();
    repeat (20) dirs.push_back(1);
    dirs[7] = 3;
    run_job(1, 2, 0);
    for (int r = 0; r < 3; r++) begin
      dirs.delete();
      while (dirs.size() < 150) begin
        n = $urandom_range(1, 40);
        t = $urandom_range(0, 3);
        repeat (n) dirs.push_back(t);
      end
      run_job(1, r, 0);
    end

    dirs.delete();
    dirs.push_back(3);
    for (int k = 0; k < 99; k++) dirs.push_back(k % 3);
    load_mem(0);
    rmode_a = 3;
    steps_a = 26'd100;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    t = 0;
    while (!if_a.op_valid && t < 200) begin step(); t++; end
    chk("pending_op_seen", t < 200, 1);
    repeat (3) step();
    chk("err_before_rst", err_a, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_addr", addr_a, 0);
    chk("mid_rst_valid", if_a.op_valid, 0);
    chk("mid_rst_code", if_a.op_code, 0);
    chk("mid_rst_len", if_a.op_len, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_err", err_a, 0);
    exp_a.delete();
    step();
    rst = 1'b1;
    step();
    dirs.delete();
    for (int k = 0; k < 90; k++) dirs.push_back($urandom_range(0, 2));
    run_job(0, 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
